uart_alu_pkt_ctrl: RTL and testbench
====================================

// Module: uart_alu_pkt_ctrl
// PURPOSE
//  Packet sequencer between the UART byte streams and the 32-bit ALU inside uart_mod.
//  Parses {opcode, reserved, len_lsb, len_msb, payload}, then either echoes the payload or
//  feeds 32-bit operands to the ALU. It returns the result LSB-first on the TX byte stream.
//  One packet is in flight at a time; the controller owns rx_tready_o and the ALU start.
// PARAMETERS
//  OP_ECHO   8'hEC  payload bytes returned unchanged
//  OP_ADD    8'hAD  acc = sum of all operands, 4-byte reply
//  OP_MUL    8'h88  acc = product of all operands (low 32b kept), 4-byte reply
//  OP_DIV    8'hA2  exactly 2 operands a/b; 8-byte reply {quotient, remainder}
// PORTS
//  clk_i        in   1   system clock
//  rst_ni       in   1   asynchronous reset, active low
//  rx_tdata_i   in   8   byte from UART receiver
//  rx_tvalid_i  in   1   rx byte valid
//  rx_tready_o  out  1   controller accepts rx byte
//  tx_tdata_o   out  8   byte to UART transmitter
//  tx_tvalid_o  out  1   tx byte valid
//  tx_tready_i  in   1   transmitter accepts byte
//  alu_op_o     out  2   0=add 1=mul 2=div, held stable from start to done
//  alu_a_o      out  32  operand A (accumulator, or dividend)
//  alu_b_o      out  32  operand B (newest operand, or divisor)
//  alu_start_o  out  1   one-cycle start pulse
//  alu_done_i   in   1   one-cycle completion pulse; alu_res_i valid that cycle
//  alu_res_i    in   64  result: [31:0] sum/product/quotient, [63:32] remainder (div)
//  busy_o       out  1   high in every state except HDR with hdr_cnt==0
//  err_o        out  1   one-cycle pulse on malformed packet
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=HDR, counters and acc cleared. Outputs: rx_tready_o=0,
//   tx_tvalid_o=0, tx_tdata_o=0, alu_start_o=0, alu_op_o=0, alu_a_o=0, alu_b_o=0,
//   busy_o=0, err_o=0. Reset mid-packet drops the partial packet; no reply is sent.
//  Handshakes: a byte transfers on tvalid&&tready. tx_tdata_o is stable while
//   tx_tvalid_o=1 and tx_tready_i=0.
//  len = {len_msb,len_lsb} is the total packet bytes incl. the 4-byte header; plen = len-4.
//  HDR: rx_tready_o=1; capture 4 bytes. On the 4th byte, the next state is chosen:
//   len<4 -> err_o pulse, HDR; plen==0 -> HDR (no reply, not an error);
//   op==ECHO -> ECHO; op ADD/MUL with plen%4==0 -> OPND;
//   op DIV with plen==8 -> OPND; anything else -> err_o pulse, DRAIN.
//  ECHO: pass-through, tx_tdata_o=rx_tdata_i, tx_tvalid_o=rx_tvalid_i,
//   rx_tready_o=tx_tready_i; zero added latency; after plen transfers -> HDR.
//  OPND: rx_tready_o=1; assemble 32b little-endian word.
//   First word of ADD/MUL loads acc, no ALU op. First word of DIV goes to alu_a.
//   Each later word -> EXEC; alu_start_o pulses the cycle after its 4th byte is accepted.
//   ADD/MUL drive a=acc, b=word; DIV drives a=dividend, b=divisor.
//   If the last word is the first and only word (ADD/MUL), go directly to RESP with result=acc.
//  EXEC: rx_tready_o=0; wait alu_done_i (no timeout). ADD/MUL: acc<=alu_res_i[31:0];
//   more operands -> OPND, else -> RESP. DIV: latch alu_res_i[63:0] -> RESP.
//  RESP: rx_tready_o=0; send 4 bytes (acc) or 8 bytes (quotient then remainder),
//   each word LSB first; next byte is presented the cycle after a transfer.
//   After the last transfer -> HDR.
//  DRAIN: rx_tready_o=1; discard plen bytes -> HDR; no reply.
//  Width rules: byte counter 16b, no wrap, since plen<=65531. MUL/ADD overflow wraps mod 2^32.
//   Divide-by-zero result is whatever the ALU returns; it is forwarded unmodified.
//  alu_done_i outside EXEC is ignored. rx bytes arriving in EXEC/RESP are held upstream (not lost).
// TESTING
//  1 ECHO: EC 00 07 00 11 22 33 -> tx 11 22 33; no ALU start; busy_o low afterward.
//  2 ADD 3 operands: AD 00 10 00 + words 1,2,3 (LE bytes) -> 2 alu starts, tx 06 00 00 00.
//  3 DIV: A2 00 0C 00 + a=100, b=7 -> 1 start, alu_op_o=2, tx 0E 00 00 00 02 00 00 00.
//  4 Malformed: opcode 0x55 len=8, then ADD len=6 -> err_o pulse each time,
//    payload drained, no tx; a following valid ADD still replies correctly.
//  5 Backpressure: tx_tready_i toggled 1-of-3 during RESP -> bytes stable, order kept, none lost.
//  6 Reset mid-OPND: rst_ni low 3 cycles -> outputs at reset values; next packet processed normally.

Source files
------------

// File: rtl/uart_alu_pkt_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_alu_pkt_ctrl_if                                              |
// | Brief  : Byte-stream and ALU handshake bundle for the packet controller.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface uart_alu_pkt_ctrl_if;
  logic [7:0]  rx_tdata_i;
  logic        rx_tvalid_i;
  logic        rx_tready_o;
  logic [7:0]  tx_tdata_o;
  logic        tx_tvalid_o;
  logic        tx_tready_i;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_start_o;
  logic        alu_done_i;
  logic [63:0] alu_res_i;
  logic        busy_o;
  logic        err_o;

  // Controller side
  modport master (
    input  rx_tdata_i, rx_tvalid_i, tx_tready_i, alu_done_i, alu_res_i,
    output rx_tready_o, tx_tdata_o, tx_tvalid_o, alu_op_o, alu_a_o, alu_b_o,
           alu_start_o, busy_o, err_o
  );

  // UART / ALU side
  modport slave (
    output rx_tdata_i, rx_tvalid_i, tx_tready_i, alu_done_i, alu_res_i,
    input  rx_tready_o, tx_tdata_o, tx_tvalid_o, alu_op_o, alu_a_o, alu_b_o,
           alu_start_o, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_alu_pkt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_alu_pkt_ctrl                                                 |
// | Brief  : Parses {op, rsvd, len_lsb, len_msb, payload} packets from the     |
// |          UART RX stream, echoes or runs them through the 32-bit ALU and    |
// |          returns the result LSB-first on the TX stream.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_alu_pkt_ctrl #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'hAD,
  parameter logic [7:0] OP_MUL  = 8'h88,
  parameter logic [7:0] OP_DIV  = 8'hA2
) (
  input  wire                 clk_i,
  input  wire                 rst_ni,
  uart_alu_pkt_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_ECHO  = 3'd1,
    S_OPND  = 3'd2,
    S_EXEC  = 3'd3,
    S_RESP  = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  state_t      r_state;
  logic [1:0]  r_hdr_cnt;
  logic [7:0]  r_op;
  logic [7:0]  r_len_lsb;
  logic [15:0] r_cnt;       // payload bytes still to be consumed
  logic [1:0]  r_byte_idx;  // byte position inside the current operand word
  logic [23:0] r_word;      // lower three bytes of the operand being assembled
  logic        r_first;     // next completed word is the first operand
  logic [31:0] r_acc;
  logic [63:0] r_res;       // reply shift register, LSB byte goes out first
  logic [3:0]  r_resp_cnt;  // reply bytes still to send, including the current one
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_rx_ready;
  logic        r_alu_start;
  logic [1:0]  r_alu_op;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_err;

  logic        w_echo;
  logic        w_rx_fire;
  logic        w_tx_fire;
  logic [15:0] w_len;
  logic [15:0] w_plen;
  logic [31:0] w_word;
  logic        w_is_div;

  // Echo is a zero-latency pass-through; every other state drives registered outputs
  assign w_echo          = (r_state == S_ECHO);
  assign bus.tx_tdata_o  = w_echo ? bus.rx_tdata_i  : r_tx_data;
  assign bus.tx_tvalid_o = w_echo ? bus.rx_tvalid_i : r_tx_valid;
  assign bus.rx_tready_o = w_echo ? bus.tx_tready_i : r_rx_ready;
  assign bus.alu_start_o = r_alu_start;
  assign bus.alu_op_o    = r_alu_op;
  assign bus.alu_a_o     = r_alu_a;
  assign bus.alu_b_o     = r_alu_b;
  assign bus.err_o       = r_err;
  assign bus.busy_o      = !((r_state == S_HDR) && (r_hdr_cnt == 2'd0));

  assign w_rx_fire = bus.rx_tvalid_i && bus.rx_tready_o;
  assign w_tx_fire = bus.tx_tvalid_o && bus.tx_tready_i;
  assign w_len     = {bus.rx_tdata_i, r_len_lsb};
  assign w_plen    = w_len - 16'd4;
  assign w_word    = {bus.rx_tdata_i, r_word};
  assign w_is_div  = (r_op == OP_DIV);

  // Packet sequencer: header parse, operand assembly, ALU handshake and reply serialisation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_HDR;
      r_hdr_cnt   <= 2'd0;
      r_op        <= 8'h00;
      r_len_lsb   <= 8'h00;
      r_cnt       <= 16'd0;
      r_byte_idx  <= 2'd0;
      r_word      <= 24'd0;
      r_first     <= 1'b0;
      r_acc       <= 32'd0;
      r_res       <= 64'd0;
      r_resp_cnt  <= 4'd0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_rx_ready  <= 1'b0;
      r_alu_start <= 1'b0;
      r_alu_op    <= 2'd0;
      r_alu_a     <= 32'd0;
      r_alu_b     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_HDR: begin
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
              2'd0: r_op      <= bus.rx_tdata_i;
              2'd2: r_len_lsb <= bus.rx_tdata_i;
              2'd3: begin
                r_cnt      <= w_plen;
                r_byte_idx <= 2'd0;
                r_first    <= 1'b1;
                if (w_len < 16'd4) begin
                  r_err <= 1'b1;
                end else if (w_plen == 16'd0) begin
                  r_state <= S_HDR;
                end else if (r_op == OP_ECHO) begin
                  r_state <= S_ECHO;
                end else if (((r_op == OP_ADD) || (r_op == OP_MUL)) && (w_plen[1:0] == 2'd0)) begin
                  r_state  <= S_OPND;
                  r_alu_op <= (r_op == OP_ADD) ? 2'd0 : 2'd1;
                end else if (w_is_div && (w_plen == 16'd8)) begin
                  r_state  <= S_OPND;
                  r_alu_op <= 2'd2;
                end else begin
                  r_err   <= 1'b1;
                  r_state <= S_DRAIN;
                end
              end
              default: ;  // reserved byte is ignored
            endcase
          end
        end

        S_ECHO: begin
          if (w_rx_fire) begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              r_state    <= S_HDR;
              r_rx_ready <= 1'b1;
            end
          end
        end

        S_OPND: begin
          if (w_rx_fire) begin
            r_word     <= {bus.rx_tdata_i, r_word[23:8]};
            r_cnt      <= r_cnt - 16'd1;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_first <= 1'b0;
              if (r_first) begin
                if (w_is_div) begin
                  r_alu_a <= w_word;
                end else begin
                  r_acc <= w_word;
                  // A lone ADD/MUL operand is its own result
                  if (r_cnt == 16'd1) begin
                    r_state    <= S_RESP;
                    r_rx_ready <= 1'b0;
                    r_res      <= {32'd0, w_word};
                    r_tx_data  <= w_word[7:0];
                    r_tx_valid <= 1'b1;
                    r_resp_cnt <= 4'd4;
                  end
                end
              end else begin
                r_alu_b <= w_word;
                if (!w_is_div) begin
                  r_alu_a <= r_acc;
                end
                r_alu_start <= 1'b1;
                r_state     <= S_EXEC;
                r_rx_ready  <= 1'b0;
              end
            end
          end
        end

        S_EXEC: begin
          if (bus.alu_done_i) begin
            if (w_is_div) begin
              r_state    <= S_RESP;
              r_res      <= bus.alu_res_i;
              r_tx_data  <= bus.alu_res_i[7:0];
              r_tx_valid <= 1'b1;
              r_resp_cnt <= 4'd8;
            end else begin
              r_acc <= bus.alu_res_i[31:0];
              if (r_cnt == 16'd0) begin
                r_state    <= S_RESP;
                r_res      <= {32'd0, bus.alu_res_i[31:0]};
                r_tx_data  <= bus.alu_res_i[7:0];
                r_tx_valid <= 1'b1;
                r_resp_cnt <= 4'd4;
              end else begin
                r_state    <= S_OPND;
                r_rx_ready <= 1'b1;
              end
            end
          end
        end

        S_RESP: begin
          if (w_tx_fire) begin
            if (r_resp_cnt == 4'd1) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_HDR;
              r_rx_ready <= 1'b1;
            end else begin
              r_res      <= {8'h00, r_res[63:8]};
              r_tx_data  <= r_res[15:8];
              r_resp_cnt <= r_resp_cnt - 4'd1;
            end
          end
        end

        S_DRAIN: begin
          if (w_rx_fire) begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              r_state <= S_HDR;
            end
          end
        end

        default: begin
          r_state    <= S_HDR;
          r_rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_pkt_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module : tb_uart_alu_pkt_ctrl                                              |
// | Brief  : Scoreboard bench for the UART/ALU packet controller.              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_uart_alu_pkt_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_alu_pkt_ctrl_if bus();

  uart_alu_pkt_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int         n_checks  = 0;
  int         n_errors  = 0;
  int         start_cnt = 0;
  int         err_cnt   = 0;
  int         bp_mode   = 0;
  logic [1:0] last_op   = 2'd3;
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TX ready: always 1, or high one cycle in three under backpressure
  initial begin
    int ph;
    ph = 0;
    bus.tx_tready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode != 0) begin
        ph = (ph + 1) % 3;
        bus.tx_tready_i = (ph == 0);
      end else begin
        bus.tx_tready_i = 1'b1;
      end
    end
  end

  // Behavioural ALU: done three cycles after start
  initial begin
    logic [1:0]  op;
    logic [31:0] a, b, r32;
    bus.alu_done_i = 1'b0;
    bus.alu_res_i  = 64'd0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.alu_start_o) begin
        op = bus.alu_op_o; a = bus.alu_a_o; b = bus.alu_b_o;
        start_cnt++;
        last_op = op;
        repeat (3) @(posedge clk);
        #1;
        chk("alu_op_held", {62'd0, bus.alu_op_o}, {62'd0, op});
        case (op)
          2'd0: begin r32 = a + b; bus.alu_res_i = {32'd0, r32}; end
          2'd1: begin r32 = a * b; bus.alu_res_i = {32'd0, r32}; end
          default: bus.alu_res_i = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        bus.alu_done_i = 1'b1;
        @(posedge clk); #1;
        bus.alu_done_i = 1'b0;
      end
    end
  end

  // Monitor: pops expected TX bytes on each transfer and checks hold-under-backpressure
  initial begin
    logic       pend;
    logic [7:0] pend_data;
    pend = 1'b0;
    pend_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("tx_hold_valid", {63'd0, bus.tx_tvalid_o}, 64'd1);
          chk("tx_hold_data", {56'd0, bus.tx_tdata_o}, {56'd0, pend_data});
        end
        if (bus.tx_tvalid_o && bus.tx_tready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_tx", {56'd0, bus.tx_tdata_o}, 64'hDEAD_0000_0000_0000);
          end else begin
            chk("tx_byte", {56'd0, bus.tx_tdata_o}, {56'd0, exp_q.pop_front()});
          end
        end
        pend = bus.tx_tvalid_o && !bus.tx_tready_i;
        pend_data = bus.tx_tdata_o;
        if (bus.err_o) err_cnt++;
      end
    end
  end

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) pkt.push_back(w[8*i +: 8]);
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte transferred
  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.rx_tdata_i  = b;
    bus.rx_tvalid_i = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.rx_tready_o) break;
      n++;
    end
    if (n >= 200) chk("rx_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.rx_tvalid_i = 1'b0;
  endtask

  task automatic send_pkt();
    while (pkt.size() != 0) send_byte(pkt.pop_front());
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (!bus.busy_o && (exp_q.size() == 0)) break;
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    int s0, e0;
    rst_n = 1'b0;
    bus.rx_tvalid_i = 1'b0;
    bus.rx_tdata_i  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {51'd0, bus.rx_tready_o, bus.tx_tvalid_o, bus.tx_tdata_o, bus.alu_start_o,
                     bus.alu_op_o, bus.busy_o, bus.err_o}, 64'd0);
    chk("rst_alu_ab", {bus.alu_a_o, bus.alu_b_o}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: echo
    s0 = start_cnt;
    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_pkt(); wait_idle();
    chk("echo_starts", 64'(start_cnt - s0), 64'd0);
    chk("echo_busy_low", {63'd0, bus.busy_o}, 64'd0);

    // 2: ADD of 1,2,3
    s0 = start_cnt;
    pkt = '{8'hAD, 8'h00, 8'h10, 8'h00};
    add_word(32'd1); add_word(32'd2); add_word(32'd3);
    expect_word(32'd6);
    send_pkt(); wait_idle();
    chk("add3_starts", 64'(start_cnt - s0), 64'd2);

    // 3: DIV 100/7
    s0 = start_cnt;
    pkt = '{8'hA2, 8'h00, 8'h0C, 8'h00};
    add_word(32'd100); add_word(32'd7);
    expect_word(32'd14); expect_word(32'd2);
    send_pkt(); wait_idle();
    chk("div_starts", 64'(start_cnt - s0), 64'd1);
    chk("div_op", {62'd0, last_op}, 64'd2);

    // 4: malformed packets, then a good ADD
    e0 = err_cnt;
    pkt = '{8'h55, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(); wait_idle();
    chk("bad_op_err", 64'(err_cnt - e0), 64'd1);
    e0 = err_cnt;
    pkt = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h09, 8'h0A};
    send_pkt(); wait_idle();
    chk("bad_len_err", 64'(err_cnt - e0), 64'd1);
    e0 = err_cnt;
    pkt = '{8'hAD, 8'h00, 8'h02, 8'h00};
    send_pkt(); wait_idle();
    chk("short_len_err", 64'(err_cnt - e0), 64'd1);
    e0 = err_cnt;
    pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
    send_pkt(); wait_idle();
    chk("empty_payload_no_err", 64'(err_cnt - e0), 64'd0);
    s0 = start_cnt;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00};
    add_word(32'd10); add_word(32'd20);
    expect_word(32'd30);
    send_pkt(); wait_idle();
    chk("add_after_err_starts", 64'(start_cnt - s0), 64'd1);

    // Single-operand ADD returns the operand without an ALU op
    s0 = start_cnt;
    pkt = '{8'hAD, 8'h00, 8'h08, 8'h00};
    add_word(32'h1234_5678);
    expect_word(32'h1234_5678);
    send_pkt(); wait_idle();
    chk("add1_starts", 64'(start_cnt - s0), 64'd0);

    // MUL wraps mod 2^32: 0x10000 * 0x10001 = 0x1_0001_0000
    pkt = '{8'h88, 8'h00, 8'h0C, 8'h00};
    add_word(32'h0001_0000); add_word(32'h0001_0001);
    expect_word(32'h0001_0000);
    send_pkt(); wait_idle();
    chk("mul_op", {62'd0, last_op}, 64'd1);

    // 5: backpressure on the reply
    bp_mode = 1;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00};
    add_word(32'hFFFF_FFFF); add_word(32'd2);
    expect_word(32'd1);
    send_pkt(); wait_idle();
    pkt = '{8'hA2, 8'h00, 8'h0C, 8'h00};
    add_word(32'd4099); add_word(32'd16);
    expect_word(32'd256); expect_word(32'd3);
    send_pkt(); wait_idle();
    bp_mode = 0;

    // 6: reset in the middle of an operand
    s0 = start_cnt;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00};
    send_pkt();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {51'd0, bus.rx_tready_o, bus.tx_tvalid_o, bus.tx_tdata_o, bus.alu_start_o,
                        bus.alu_op_o, bus.busy_o, bus.err_o}, 64'd0);
    chk("midrst_alu_ab", {bus.alu_a_o, bus.alu_b_o}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", {63'd0, bus.busy_o}, 64'd0);
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00};
    add_word(32'd3); add_word(32'd4);
    expect_word(32'd7);
    send_pkt(); wait_idle();
    chk("post_rst_starts", 64'(start_cnt - s0), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
